car_gate_sensor_fsm: RTL
========================

// Module: car_gate_sensor_fsm
// PURPOSE
// Upstream front end of ParkingSystem. Decodes two raw beam sensors at the lot gate
// (sensor_a outer, sensor_b inner) into direction-qualified single-cycle inc_car/dec_car
// pulses and drives the entry barrier. Free-slot status comes back from ParkingSystem as 'full'.
// Each raw sensor is synchronised and debounced; an ordered-event FSM rejects aborts,
// ambiguous events and stuck sensors.
// PARAMETERS
// DEBOUNCE_CYCLES  16   consecutive stable synced samples needed to change a debounced level (>=2)
// TIMEOUT_CYCLES   1000 max cycles in any non-IDLE transit state before fault
// CNT_W            10   width of timeout counter (must hold TIMEOUT_CYCLES)
// PORTS
// clk        in   1  system clock, rising-edge, single domain
// reset      in   1  synchronous, active-low reset
// enable     in   1  counting enable (tied to ParkingSystem start); 0 = FSM held in IDLE
// sensor_a   in   1  raw outer beam, 1 = blocked, asynchronous
// sensor_b   in   1  raw inner beam, 1 = blocked, asynchronous
// full       in   1  1 = no free slots (free_slots==0 from ParkingSystem)
// inc_car    out  1  one-cycle pulse: completed entry
// dec_car    out  1  one-cycle pulse: completed exit
// gate_open  out  1  entry barrier open command
// deny       out  1  one-cycle pulse: entry attempt while full
// fault      out  1  one-cycle pulse: timeout or ambiguous sensor event
// busy       out  1  FSM not in IDLE
// BEHAVIOUR
// - Reset (reset==0 at rising clk): all outputs 0, FSM=IDLE, debounced levels 0, sync flops 0,
//   all counters 0. Reset mid-transit aborts silently: no pulse, no fault.
// - Sync: 2-flop synchroniser per sensor. Debounce: counter clears when synced != debounced and
//   differs from the previous sample; debounced level flips on the edge where DEBOUNCE_CYCLES
//   consecutive equal differing samples are seen. Raw-to-debounced latency = 2+DEBOUNCE_CYCLES clks.
//   Glitches shorter than DEBOUNCE_CYCLES are never seen by the FSM.
// - FSM acts on debounced A/B (da, db). States, decided order:
//   IDLE:   da&!db -> full ? (deny pulse, WAIT_CLR) : EN_A;  db&!da -> EX_B;  da&db -> fault, WAIT_CLR
//   EN_A:   db -> EN_AB;  !da -> IDLE (abort, no pulse)
//   EN_AB:  !da&db -> EN_B;  da&!db -> EN_A;  !da&!db -> fault, IDLE
//   EN_B:   !da&!db -> inc_car pulse, IDLE;  da&db -> EN_AB;  da&!db -> fault, WAIT_CLR
//   EX_B/EX_BA/EX_A mirror EN_* with A,B swapped; completion from EX_A -> dec_car pulse.
//   WAIT_CLR: stay until !da&!db, then IDLE; no pulses issued.
// - gate_open = 1 in EN_A, EN_AB, EN_B (registered, asserted the cycle after EN_A is entered);
//   0 in all other states. 'full' rising mid-entry does NOT close the gate or cancel inc_car.
// - Timeout: counter clears on every state change, increments each cycle in EN_*/EX_*;
//   on reaching TIMEOUT_CYCLES -> fault pulse, go WAIT_CLR. Saturates, never wraps.
//   WAIT_CLR has no timeout.
// - enable==0: FSM forced to IDLE next cycle, no pulses, gate_open=0; debouncers keep running.
//   If enable rises while a sensor is already blocked, the transit is treated as fresh from IDLE.
// - All pulse outputs are registered, high exactly 1 clk, asserted the cycle after the qualifying
//   transition. inc_car and dec_car are never high in the same cycle.
// - busy = (state != IDLE), registered.
// TESTING (DEBOUNCE_CYCLES=4, TIMEOUT_CYCLES=50)
// 1 Entry: A=1 @t0, B=1 @t0+20, A=0 @t0+40, B=0 @t0+60 -> exactly one inc_car pulse 7 clks after
//   B falls; gate_open high from EN_A until IDLE; dec_car, fault stay 0.
// 2 Exit: B-then-A mirror of 1 -> one dec_car pulse, gate_open never asserted.
// 3 Full and glitch: full=1, A blocked 20 clks -> one deny pulse, no gate_open, no inc_car;
//   then 3-clk glitch on B -> no FSM change, busy stays 0.
// 4 Abort and ambiguity: A=1 then A=0 before B -> back to IDLE, no pulses; A,B raised same
//   cycle -> one fault pulse, WAIT_CLR until both clear.
// 5 Timeout/reset: A held blocked 60 clks -> fault at 50 clks in EN_A, WAIT_CLR; reset=0 mid
//   EN_AB -> all outputs 0 next clk, no pulses after release.

Source files
------------

// File: rtl/car_gate_sensor_fsm.sv
// Lot-gate front end: synchronises and debounces the outer (A) and inner (B) beams and
// decodes ordered A/B events into entry/exit pulses, barrier control, deny and fault.
module car_gate_sensor_fsm #(
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int TIMEOUT_CYCLES  = 1000,
    parameter int CNT_W           = 10
) (
    input  logic clk,
    input  logic reset,
    input  logic enable,
    input  logic sensor_a,
    input  logic sensor_b,
    input  logic full,
    output logic inc_car,
    output logic dec_car,
    output logic gate_open,
    output logic deny,
    output logic fault,
    output logic busy
);
    localparam int                DB_W     = $clog2(DEBOUNCE_CYCLES);
    localparam logic [DB_W-1:0]   DB_LAST  = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0]  TMO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_EN_A, S_EN_AB, S_EN_B, S_EX_B, S_EX_BA, S_EX_A, S_WAIT_CLR
    } state_t;

    // Bit 0 carries beam A, bit 1 carries beam B through the sync/debounce pipeline.
    logic [1:0]       w_raw;
    logic [1:0]       r_sync1, r_sync2, r_deb;
    logic [DB_W-1:0]  r_db_cnt [2];
    logic             w_da, w_db;

    assign w_raw = {sensor_b, sensor_a};
    assign w_da  = r_deb[0];
    assign w_db  = r_deb[1];

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
            r_deb   <= '0;
            for (int i = 0; i < 2; i++) r_db_cnt[i] <= '0;
        end else begin
            r_sync1 <= w_raw;
            r_sync2 <= r_sync1;
            for (int i = 0; i < 2; i++) begin
                if (r_sync2[i] == r_deb[i]) begin
                    r_db_cnt[i] <= '0;
                end else if (r_db_cnt[i] == DB_LAST) begin
                    r_deb[i]    <= r_sync2[i];
                    r_db_cnt[i] <= '0;
                end else begin
                    r_db_cnt[i] <= r_db_cnt[i] + 1'b1;
                end
            end
        end
    end

    state_t           r_state, w_next;
    logic [CNT_W-1:0] r_tmo;
    logic             w_transit, w_tmo_hit;
    logic             w_inc, w_dec, w_deny, w_fault;
    logic             r_inc, r_dec, r_deny, r_fault, r_gate, r_busy;

    assign w_transit = (r_state != S_IDLE) && (r_state != S_WAIT_CLR);
    assign w_tmo_hit = w_transit && (r_tmo == TMO_LAST);

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        w_next  = r_state;
        w_inc   = 1'b0;
        w_dec   = 1'b0;
        w_deny  = 1'b0;
        w_fault = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_da && !w_db) begin
                    if (full) begin
                        w_deny = 1'b1;
                        w_next = S_WAIT_CLR;
                    end else begin
                        w_next = S_EN_A;
                    end
                end else if (w_db && !w_da) begin
                    w_next = S_EX_B;
                end else if (w_da && w_db) begin
                    w_fault = 1'b1;
                    w_next  = S_WAIT_CLR;
                end
            end
            S_EN_A: begin
                if (w_db)       w_next = S_EN_AB;
                else if (!w_da) w_next = S_IDLE;
            end
            S_EN_AB: begin
                if (!w_da && w_db)      w_next = S_EN_B;
                else if (w_da && !w_db) w_next = S_EN_A;
                else if (!w_da && !w_db) begin
                    w_fault = 1'b1;
                    w_next  = S_IDLE;
                end
            end
            S_EN_B: begin
                if (!w_da && !w_db) begin
                    w_inc  = 1'b1;
                    w_next = S_IDLE;
                end else if (w_da && w_db) begin
                    w_next = S_EN_AB;
                end else if (w_da && !w_db) begin
                    w_fault = 1'b1;
                    w_next  = S_WAIT_CLR;
                end
            end
            S_EX_B: begin
                if (w_da)       w_next = S_EX_BA;
                else if (!w_db) w_next = S_IDLE;
            end
            S_EX_BA: begin
                if (!w_db && w_da)      w_next = S_EX_A;
                else if (w_db && !w_da) w_next = S_EX_B;
                else if (!w_da && !w_db) begin
                    w_fault = 1'b1;
                    w_next  = S_IDLE;
                end
            end
            S_EX_A: begin
                if (!w_da && !w_db) begin
                    w_dec  = 1'b1;
                    w_next = S_IDLE;
                end else if (w_da && w_db) begin
                    w_next = S_EX_BA;
                end else if (w_db && !w_da) begin
                    w_fault = 1'b1;
                    w_next  = S_WAIT_CLR;
                end
            end
            S_WAIT_CLR: begin
                if (!w_da && !w_db) w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase

        // A genuine sensor event in the final cycle wins over the timeout.
        if (w_tmo_hit && (w_next == r_state)) begin
            w_fault = 1'b1;
            w_next  = S_WAIT_CLR;
        end

        if (!enable) begin
            w_next  = S_IDLE;
            w_inc   = 1'b0;
            w_dec   = 1'b0;
            w_deny  = 1'b0;
            w_fault = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= S_IDLE;
            r_tmo   <= '0;
            r_inc   <= 1'b0;
            r_dec   <= 1'b0;
            r_deny  <= 1'b0;
            r_fault <= 1'b0;
            r_gate  <= 1'b0;
            r_busy  <= 1'b0;
        end else begin
            r_state <= w_next;
            if (w_next != r_state)
                r_tmo <= '0;
            else if (w_transit && (r_tmo != {CNT_W{1'b1}}))
                r_tmo <= r_tmo + 1'b1;
            r_inc   <= w_inc;
            r_dec   <= w_dec;
            r_deny  <= w_deny;
            r_fault <= w_fault;
            r_gate  <= (w_next == S_EN_A) || (w_next == S_EN_AB) || (w_next == S_EN_B);
            r_busy  <= (w_next != S_IDLE);
        end
    end

    assign inc_car   = r_inc;
    assign dec_car   = r_dec;
    assign deny      = r_deny;
    assign fault     = r_fault;
    assign gate_open = r_gate;
    assign busy      = r_busy;

endmodule
